control_sequencer: RTL and testbench

- Multi-cycle control unit for the 4-bit processor, directly downstream of the instruction register.
- Consumes the registered OpCode/Operand fields and ALU flags.
- Drives instruction-register load, program-counter increment/load, ALU select, accumulator load and data-memory strobes through a fixed fetch/decode/execute sequence.

---
 rtl/control_sequencer.sv | 146 ++++++++++++++
 tb/tb_control_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Fetch/decode/execute control FSM for the 4-bit processor.
// Optional macro SINGLE_STEP_EN adds a Step input that gates each FETCH.
module control_sequencer #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 4
) (
  input  logic              Clk,
  input  logic              Rst,
`ifdef SINGLE_STEP_EN
  input  logic              Step,
`endif
  input  logic [3:0]        OpCode,
  input  logic [3:0]        Operand,
  input  logic              Zero_Flag,
  input  logic              Carry_Flag,
  output logic              IR_Load,
  output logic              PC_Inc,
  output logic              PC_Load,
  output logic [ADDR_W-1:0] Jump_Addr,
  output logic [2:0]        ALU_Sel,
  output logic              Acc_Load,
  output logic              Acc_Src,
  output logic              Mem_Rd,
  output logic              Mem_Wr,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Halted,
  output logic [2:0]        State
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_opcode;
  logic [3:0]  r_operand;
  logic [2:0]  r_cnt;
  logic        w_last;
  logic [ADDR_W-1:0] w_opnd_addr;

  assign w_last      = (r_cnt == 3'd1);
  assign w_opnd_addr = ADDR_W'(r_operand);
  assign State       = r_state;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state   <= S_IDLE;
      r_opcode  <= 4'd0;
      r_operand <= 4'd0;
      r_cnt     <= 3'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_opcode  <= OpCode;
        r_operand <= Operand;
      end
      // Counter is armed in EXEC and counts down through the MEM cycles.
      if (r_state == S_EXEC)
        r_cnt <= 3'(MEM_LAT);
      else if (r_state == S_MEM && r_cnt != 3'd0)
        r_cnt <= r_cnt - 3'd1;
    end
  end

  always_comb begin
    w_next    = r_state;
    IR_Load   = 1'b0;
    PC_Inc    = 1'b0;
    PC_Load   = 1'b0;
    Jump_Addr = '0;
    ALU_Sel   = 3'd0;
    Acc_Load  = 1'b0;
    Acc_Src   = 1'b0;
    Mem_Rd    = 1'b0;
    Mem_Wr    = 1'b0;
    Mem_Addr  = '0;
    Halted    = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
`ifdef SINGLE_STEP_EN
        if (Step) begin
          IR_Load = 1'b1;
          PC_Inc  = 1'b1;
          w_next  = S_DECODE;
        end
`else
        IR_Load = 1'b1;
        PC_Inc  = 1'b1;
        w_next  = S_DECODE;
`endif
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        w_next = S_FETCH;
        case (r_opcode)
          // LDI..INC map onto ALU select opcode-1 (LDI is pass-B).
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
            ALU_Sel  = 3'(r_opcode - 4'd1);
            Acc_Load = 1'b1;
          end
          4'h9, 4'hA: begin
            Mem_Addr = w_opnd_addr;
            w_next   = S_MEM;
          end
          4'hB: begin
            PC_Load   = 1'b1;
            Jump_Addr = w_opnd_addr;
          end
          4'hC: begin
            PC_Load   = Zero_Flag;
            Jump_Addr = Zero_Flag ? w_opnd_addr : '0;
          end
          4'hD: begin
            PC_Load   = Carry_Flag;
            Jump_Addr = Carry_Flag ? w_opnd_addr : '0;
          end
          4'hF: w_next = S_HALT;
          default: ;
        endcase
      end
      S_MEM: begin
        Mem_Addr = w_opnd_addr;
        Mem_Rd   = (r_opcode == 4'h9);
        Mem_Wr   = (r_opcode == 4'hA);
        if (w_last) begin
          Acc_Load = (r_opcode == 4'h9);
          Acc_Src  = (r_opcode == 4'h9);
          w_next   = S_FETCH;
        end
      end
      S_HALT: begin
        Halted = 1'b1;
        w_next = S_HALT;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer (MEM_LAT=3): driver queues the expected
// output vector per cycle, a negedge monitor pops and compares.
module tb_control_sequencer;

  typedef struct packed {
    logic       ir;
    logic       pinc;
    logic       pld;
    logic [3:0] ja;
    logic [2:0] alu;
    logic       accl;
    logic       accs;
    logic       mrd;
    logic       mwr;
    logic [3:0] ma;
    logic       hlt;
    logic [2:0] st;
  } vec_t;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [3:0] OpCode = 4'd0;
  logic [3:0] Operand = 4'd0;
  logic       Zero_Flag = 1'b0;
  logic       Carry_Flag = 1'b0;
  logic       IR_Load, PC_Inc, PC_Load, Acc_Load, Acc_Src, Mem_Rd, Mem_Wr, Halted;
  logic [3:0] Jump_Addr, Mem_Addr;
  logic [2:0] ALU_Sel, State;
`ifdef SINGLE_STEP_EN
  logic       Step = 1'b1;
`endif

  logic       n_rst = 1'b0;
  logic [3:0] n_op = 4'd0;
  logic [3:0] n_opd = 4'd0;
  logic       n_z = 1'b0;
  logic       n_c = 1'b0;
  logic       n_step = 1'b1;

  vec_t  exp_q[$];
  string nm_q[$];
  int    n_checks = 0;
  int    n_pass = 0;

  control_sequencer #(.MEM_LAT(3), .ADDR_W(4)) dut (
    .Clk(Clk), .Rst(Rst),
`ifdef SINGLE_STEP_EN
    .Step(Step),
`endif
    .OpCode(OpCode), .Operand(Operand), .Zero_Flag(Zero_Flag), .Carry_Flag(Carry_Flag),
    .IR_Load(IR_Load), .PC_Inc(PC_Inc), .PC_Load(PC_Load), .Jump_Addr(Jump_Addr),
    .ALU_Sel(ALU_Sel), .Acc_Load(Acc_Load), .Acc_Src(Acc_Src), .Mem_Rd(Mem_Rd),
    .Mem_Wr(Mem_Wr), .Mem_Addr(Mem_Addr), .Halted(Halted), .State(State)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      vec_t  a;
      vec_t  e;
      string nm;
      e = exp_q.pop_front();
      nm = nm_q.pop_front();
      a.ir = IR_Load;   a.pinc = PC_Inc;   a.pld = PC_Load;  a.ja = Jump_Addr;
      a.alu = ALU_Sel;  a.accl = Acc_Load; a.accs = Acc_Src; a.mrd = Mem_Rd;
      a.mwr = Mem_Wr;   a.ma = Mem_Addr;   a.hlt = Halted;   a.st = State;
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  end

  function automatic vec_t v(input logic [2:0] st);
    v = '0;
    v.st = st;
  endfunction

  task automatic cyc(input string nm, input vec_t e);
    @(posedge Clk);
    #1;
    Rst = n_rst; OpCode = n_op; Operand = n_opd; Zero_Flag = n_z; Carry_Flag = n_c;
`ifdef SINGLE_STEP_EN
    Step = n_step;
`endif
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic fetch();
    vec_t e;
    e = v(3'd1); e.ir = 1'b1; e.pinc = 1'b1;
    cyc("fetch", e);
  endtask

  // Inputs are scrambled after DECODE to prove later cycles use latched copies.
  task automatic decode(input logic [3:0] op, input logic [3:0] opd);
    n_op = op; n_opd = opd;
    cyc("decode", v(3'd2));
    n_op = ~op; n_opd = ~opd;
  endtask

  initial begin
    vec_t e;
    n_op = 4'hF; n_opd = 4'hF;
    cyc("reset0", v(3'd0));
    cyc("reset1", v(3'd0));
    n_rst = 1'b1;
    cyc("idle_gap", v(3'd0));
    fetch();

    decode(4'h2, 4'h5);
    e = v(3'd3); e.alu = 3'd1; e.accl = 1'b1; cyc("add_exec", e);
    fetch();

    decode(4'hC, 4'h9);
    n_z = 1'b1;
    e = v(3'd3); e.pld = 1'b1; e.ja = 4'h9; cyc("jz_taken", e);
    n_z = 1'b0;
    fetch();

    decode(4'hC, 4'h9);
    n_c = 1'b1;
    cyc("jz_not_taken", v(3'd3));
    n_c = 1'b0;
    fetch();

    decode(4'hD, 4'h4);
    n_c = 1'b1;
    e = v(3'd3); e.pld = 1'b1; e.ja = 4'h4; cyc("jc_taken", e);
    n_c = 1'b0;
    fetch();

    decode(4'hB, 4'h7);
    e = v(3'd3); e.pld = 1'b1; e.ja = 4'h7; cyc("jmp_exec", e);
    fetch();

    decode(4'h1, 4'h6);
    e = v(3'd3); e.alu = 3'd0; e.accl = 1'b1; cyc("ldi_exec", e);
    fetch();

    decode(4'h9, 4'h3);
    e = v(3'd3); e.ma = 4'h3; cyc("lda_exec", e);
    e = v(3'd4); e.mrd = 1'b1; e.ma = 4'h3; cyc("lda_mem1", e);
    cyc("lda_mem2", e);
    e.accl = 1'b1; e.accs = 1'b1; cyc("lda_mem3", e);
    fetch();

    decode(4'hA, 4'hA);
    e = v(3'd3); e.ma = 4'hA; cyc("sta_exec", e);
    e = v(3'd4); e.mwr = 1'b1; e.ma = 4'hA; cyc("sta_mem1", e);
    n_rst = 1'b0;
    cyc("sta_rst_mid", v(3'd0));
    cyc("sta_rst_hold", v(3'd0));
    n_rst = 1'b1;
    cyc("sta_rst_idle", v(3'd0));
    fetch();

    decode(4'h7, 4'h0);
    e = v(3'd3); e.alu = 3'd6; e.accl = 1'b1; cyc("not_exec", e);
    fetch();

    decode(4'h8, 4'h0);
    e = v(3'd3); e.alu = 3'd7; e.accl = 1'b1; cyc("inc_exec", e);
    fetch();

    decode(4'hE, 4'h5);
    cyc("rsvd_exec", v(3'd3));
    fetch();

    decode(4'hF, 4'h0);
    cyc("hlt_exec", v(3'd3));
    for (int i = 0; i < 22; i++) begin
      n_op = 4'(i); n_opd = 4'(i * 3); n_z = i[0]; n_c = i[1];
      e = v(3'd5); e.hlt = 1'b1; cyc("halt_hold", e);
    end
    n_z = 1'b0; n_c = 1'b0;
    n_rst = 1'b0;
    cyc("halt_rst", v(3'd0));
    n_rst = 1'b1;
    cyc("halt_rel_idle", v(3'd0));
`ifdef SINGLE_STEP_EN
    n_step = 1'b0;
    for (int i = 0; i < 10; i++) cyc("step_hold", v(3'd1));
    n_step = 1'b1;
    fetch();
    n_step = 1'b0;
    decode(4'h3, 4'h2);
    e = v(3'd3); e.alu = 3'd2; e.accl = 1'b1; cyc("step_sub_exec", e);
    cyc("step_hold_after", v(3'd1));
    cyc("step_hold_after2", v(3'd1));
`else
    fetch();
`endif

    @(negedge Clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
